// File: rtl/input_pkg.sv
// Shared button definitions: channel index constants and repeat FSM encoding.
package input_pkg;

  localparam int BTN_NEXT   = 0;
  localparam int BTN_PLAY   = 1;
  localparam int BTN_RESET  = 2;
  localparam int BTN_WEIGHT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop sync, saturating debounce filter, press pulse.
// Optional hold-to-repeat pulses when BUTTON_BANK_REPEAT_EN is defined.
module button_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = 20,
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_RATE    = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic pulse,
  output logic held
);

  if (DEBOUNCE_WIDTH < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_cfg
    $error("button_channel: illegal parameter set");
  end

  logic                      s1, s2;
  logic [DEBOUNCE_WIDTH-1:0] cnt;
  logic                      rise;
  logic                      rep_fire;

  // Filter saturates with s2 still high while level is low: level rises next edge.
  assign rise = s2 && !level && (cnt == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= in;
      s2    <= s1;
      pulse <= rise | rep_fire;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_BANK_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  rep_state_t    state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          held_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= '0;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      held  <= held_n;
    end
  end

  // Press edge wins over the release check since level is still 0 on that edge.
  always_comb begin
    state_n  = state;
    rcnt_n   = rcnt;
    held_n   = held;
    rep_fire = 1'b0;
    if (rise) begin
      state_n = DELAY;
      rcnt_n  = '0;
      held_n  = 1'b0;
    end else if (!level) begin
      state_n = IDLE;
      rcnt_n  = '0;
      held_n  = 1'b0;
    end else begin
      case (state)
        DELAY: begin
          if (rcnt == DLY_LAST) begin
            rep_fire = 1'b1;
            rcnt_n   = '0;
            state_n  = REPEAT;
            held_n   = 1'b1;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rcnt == RATE_LAST) begin
            rep_fire = 1'b1;
            rcnt_n   = '0;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
        default: rcnt_n = '0;
      endcase
    end
  end
`else
  assign rep_fire = 1'b0;
  assign held     = 1'b0;
`endif

endmodule

// File: rtl/button_bank.sv
// N-channel button conditioner; one button_channel per pin, wiring only.
// Hold-to-repeat enabled by defining BUTTON_BANK_REPEAT_EN.
module button_bank
  import input_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int DEBOUNCE_WIDTH = 20,
  parameter int REPEAT_DELAY   = 50_000_000,
  parameter int REPEAT_RATE    = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] held
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .in    (in[i]),
      .level (level[i]),
      .pulse (pulse[i]),
      .held  (held[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: expected pulse events queued at stimulus time,
// observed pulse events collected each cycle and matched per scenario.
module tb_button_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [3:0] level, pulse, held;

  button_bank #(
    .N_BTN(4), .DEBOUNCE_WIDTH(2), .REPEAT_DELAY(8), .REPEAT_RATE(4)
  ) dut (
    .clk(clk), .reset(reset), .in(btn), .level(level), .pulse(pulse), .held(held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] mask; } ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  checks = 0;
  int  errors = 0;
  logic [3:0] held_seen;

  // Advance n cycles, sampling on the falling edge and logging pulse events.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (pulse !== 4'b0000) obs_q.push_back('{cyc, pulse});
      held_seen |= held;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 4'b0000;
    step(4);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL reset_level got %b want 0000", level); end
    checks++; if (pulse !== 4'b0000) begin errors++; $display("FAIL reset_pulse got %b want 0000", pulse); end
    checks++; if (held  !== 4'b0000) begin errors++; $display("FAIL reset_held got %b want 0000", held); end
    reset = 1'b0;
    step(3);
    obs_q.delete();
  endtask

  task automatic test_press();
    int c;
    c = cyc; btn[0] = 1'b1;
    exp_q.push_back('{c + 6, 4'b0001});
    step(5);
    checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL press_level_early got %b want 0", level[0]); end
    step(1);
    checks++; if (level[0] !== 1'b1) begin errors++; $display("FAIL press_level_rise got %b want 1", level[0]); end
    btn[0] = 1'b0;
    step(12);
    checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL press_release_level got %b want 0", level[0]); end
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL press_pulse missing want cyc %0d mask %b", e.cyc, e.mask); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.mask !== e.mask) begin errors++;
          $display("FAIL press_pulse got cyc %0d mask %b want cyc %0d mask %b", o.cyc, o.mask, e.cyc, e.mask); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL press_extra got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    int c;
    c = cyc; btn[1] = 1'b1;
    step(3); btn[1] = 1'b0;
    step(1); btn[1] = 1'b1;
    exp_q.push_back('{c + 10, 4'b0010});
    step(7); btn[1] = 1'b0;
    step(12);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL glitch_pulse missing want cyc %0d mask %b", e.cyc, e.mask); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.mask !== e.mask) begin errors++;
          $display("FAIL glitch_pulse got cyc %0d mask %b want cyc %0d mask %b", o.cyc, o.mask, e.cyc, e.mask); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_extra got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc; btn = 4'b1111;
    exp_q.push_back('{c + 6, 4'b1111});
    step(5);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL simul_level_early got %b want 0000", level); end
    step(1);
    checks++; if (level !== 4'b1111) begin errors++; $display("FAIL simul_level got %b want 1111", level); end
    btn = 4'b0000;
    step(5);
    checks++; if (level !== 4'b1111) begin errors++; $display("FAIL simul_release_early got %b want 1111", level); end
    step(1);
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL simul_release got %b want 0000", level); end
    step(8);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL simul_pulse missing want cyc %0d mask %b", e.cyc, e.mask); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.mask !== e.mask) begin errors++;
          $display("FAIL simul_pulse got cyc %0d mask %b want cyc %0d mask %b", o.cyc, o.mask, e.cyc, e.mask); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL simul_extra got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

`ifdef BUTTON_BANK_REPEAT_EN
  task automatic test_repeat();
    int c;
    c = cyc; btn[3] = 1'b1;
    exp_q.push_back('{c + 6,  4'b1000});
    exp_q.push_back('{c + 14, 4'b1000});
    exp_q.push_back('{c + 18, 4'b1000});
    exp_q.push_back('{c + 22, 4'b1000});
    exp_q.push_back('{c + 26, 4'b1000});
    step(13);
    checks++; if (held[3] !== 1'b0) begin errors++; $display("FAIL repeat_held_early got %b want 0", held[3]); end
    step(1);
    checks++; if (held[3] !== 1'b1) begin errors++; $display("FAIL repeat_held got %b want 1", held[3]); end
    step(9);
    btn[3] = 1'b0;
    step(12);
    checks++; if (held[3] !== 1'b0) begin errors++; $display("FAIL repeat_held_clear got %b want 0", held[3]); end
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL repeat_pulse missing want cyc %0d mask %b", e.cyc, e.mask); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.mask !== e.mask) begin errors++;
          $display("FAIL repeat_pulse got cyc %0d mask %b want cyc %0d mask %b", o.cyc, o.mask, e.cyc, e.mask); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL repeat_extra got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask
`else
  task automatic test_no_repeat();
    int c;
    c = cyc; btn[3] = 1'b1; held_seen = 4'b0000;
    exp_q.push_back('{c + 6, 4'b1000});
    step(100);
    btn[3] = 1'b0;
    step(12);
    checks++; if (held_seen !== 4'b0000) begin errors++; $display("FAIL norepeat_held got %b want 0000", held_seen); end
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL norepeat_pulse missing want cyc %0d mask %b", e.cyc, e.mask); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.mask !== e.mask) begin errors++;
          $display("FAIL norepeat_pulse got cyc %0d mask %b want cyc %0d mask %b", o.cyc, o.mask, e.cyc, e.mask); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL norepeat_extra got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask
`endif

  task automatic test_reset_mid();
    int d;
    btn[2] = 1'b1;
    step(3);
    reset = 1'b1;
    step(3);
    checks++; if ({level, pulse, held} !== 12'h000) begin errors++;
      $display("FAIL midreset_outputs got %b/%b/%b want all 0", level, pulse, held); end
    d = cyc; reset = 1'b0;
    exp_q.push_back('{d + 6, 4'b0100});
    step(6);
    btn[2] = 1'b0;
    step(12);
    while (exp_q.size() > 0) begin
      ev_t e, o;
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midreset_pulse missing want cyc %0d mask %b", e.cyc, e.mask); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.mask !== e.mask) begin errors++;
          $display("FAIL midreset_pulse got cyc %0d mask %b want cyc %0d mask %b", o.cyc, o.mask, e.cyc, e.mask); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_extra got %0d extra pulses want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    held_seen = 4'b0000;
    test_reset();
    test_press();
    test_glitch();
    test_simultaneous();
`ifdef BUTTON_BANK_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
